counter_seq_checker: RTL and testbench

//   Receive-side companion to the free-running counters: samples a counter's output bus
//   and checks that it advances by exactly +1 (mod 2^WIDTH) per valid sample.

---
 rtl/counter_seq_checker_if.sv | 28 ++
 rtl/counter_seq_checker.sv | 112 +++++++++++
 tb/tb_counter_seq_checker.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_seq_checker_if.sv
// Bundle between a counter under observation and its sequence checker.
// Inputs and results of the checker travel together so a monitor can be bound in one place.
interface counter_seq_checker_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    // din is qualified by din_valid alone: the checker never stalls the source,
    // so there is no ready; a sample is consumed on every rising edge with din_valid=1.
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic             restart_pulse;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] last_good;
    logic [1:0]       fsm_state;

    modport master (
        output din_valid, din, clear,
        input  locked, err_pulse, restart_pulse, err_count, last_good, fsm_state
    );

    modport slave (
        input  din_valid, din, clear,
        output locked, err_pulse, restart_pulse, err_count, last_good, fsm_state
    );
endinterface

// File: rtl/counter_seq_checker.sv
// Monitors a free-running counter bus: acquires lock on a +1 sequence, then flags
// sequence errors (counted, saturating) and upstream restarts (a jump to zero).
module counter_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_seq_checker_if.slave bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [MW-1:0]    match_q, match_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] last_good_q, last_good_d;
    logic             err_pulse_q, err_pulse_d;
    logic             restart_q, restart_d;
    logic [WIDTH-1:0] din_plus1;

    assign din_plus1 = bus.din + WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_HUNT;
            exp_q       <= '0;
            match_q     <= '0;
            err_cnt_q   <= '0;
            last_good_q <= '0;
            err_pulse_q <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            match_q     <= match_d;
            err_cnt_q   <= err_cnt_d;
            last_good_q <= last_good_d;
            err_pulse_q <= err_pulse_d;
            restart_q   <= restart_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        match_d     = match_q;
        err_cnt_d   = err_cnt_q;
        last_good_d = last_good_q;
        err_pulse_d = 1'b0;
        restart_d   = 1'b0;

        if (bus.clear) begin
            state_d     = ST_HUNT;
            exp_d       = '0;
            match_d     = '0;
            err_cnt_d   = '0;
            last_good_d = '0;
        end else if (bus.din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    state_d = ST_SYNC;
                    match_d = MW'(1);
                    exp_d   = din_plus1;
                end
                ST_SYNC: begin
                    exp_d = din_plus1;
                    if (bus.din == exp_q) begin
                        match_d = match_q + MW'(1);
                        if (match_q + MW'(1) == MW'(LOCK_CNT)) state_d = ST_LOCKED;
                    end else begin
                        match_d = MW'(1);
                    end
                end
                ST_LOCKED: begin
                    exp_d = din_plus1;
                    if (bus.din == exp_q) begin
                        last_good_d = bus.din;
                    end else begin
                        // A jump to zero is the upstream counter being reset, not a fault.
                        state_d = ST_SYNC;
                        match_d = MW'(1);
                        if (bus.din == '0) begin
                            restart_d = 1'b1;
                        end else begin
                            err_pulse_d = 1'b1;
                            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    match_d = '0;
                end
            endcase
        end
    end

    assign bus.locked        = (state_q == ST_LOCKED);
    assign bus.err_pulse     = err_pulse_q;
    assign bus.restart_pulse = restart_q;
    assign bus.err_count     = err_cnt_q;
    assign bus.last_good     = last_good_q;
    assign bus.fsm_state     = state_q;
endmodule

// File: tb/tb_counter_seq_checker.sv
// Randomised and directed bench for counter_seq_checker; two instances share stimulus,
// one with a narrow error counter so saturation is exercised alongside the default build.
module tb_counter_seq_checker;
    localparam int WIDTH     = 4;
    localparam int LOCK_CNT  = 4;
    localparam int ERR_W     = 8;
    localparam int ERR_W_SAT = 2;
    localparam int MOD       = 1 << WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    counter_seq_checker_if #(.WIDTH(WIDTH), .ERR_W(ERR_W))     bus ();
    counter_seq_checker_if #(.WIDTH(WIDTH), .ERR_W(ERR_W_SAT)) bus_sat ();

    counter_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    counter_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W_SAT)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_sat.slave)
    );

    int tests  = 0;
    int failed = 0;

    // Reference model: run length of consecutive +1 samples, previous value, lock flag.
    int m_run;
    int m_prev;
    bit m_locked;
    int m_err;
    int m_last_good;
    bit m_err_p;
    bit m_rst_p;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_prev = 0; m_locked = 0; m_err = 0;
        m_last_good = 0; m_err_p = 0; m_rst_p = 0;
    endtask

    task automatic model_sample(input bit v, input int d, input bit c);
        m_err_p = 0;
        m_rst_p = 0;
        if (c) begin
            m_run = 0; m_locked = 0; m_err = 0; m_last_good = 0;
        end else if (v) begin
            if (m_run == 0) begin
                m_run = 1;
            end else if (d == (m_prev + 1) % MOD) begin
                if (m_locked) m_last_good = d;
                else begin
                    m_run++;
                    if (m_run == LOCK_CNT) m_locked = 1;
                end
            end else begin
                if (m_locked) begin
                    if (d == 0) m_rst_p = 1;
                    else begin
                        m_err_p = 1;
                        m_err++;
                    end
                end
                m_locked = 0;
                m_run = 1;
            end
            m_prev = d;
        end
    endtask

    task automatic check_all();
        check("locked",        bus.locked,        m_locked);
        check("err_pulse",     bus.err_pulse,     m_err_p);
        check("restart_pulse", bus.restart_pulse, m_rst_p);
        check("err_count",     bus.err_count,     sat(m_err, ERR_W));
        check("last_good",     bus.last_good,     m_last_good);
        check("sat_locked",    bus_sat.locked,    m_locked);
        check("sat_err_count", bus_sat.err_count, sat(m_err, ERR_W_SAT));
    endtask

    task automatic drive(input bit v, input int d, input bit c);
        bus.din_valid     = v;
        bus.din           = WIDTH'(d);
        bus.clear         = c;
        bus_sat.din_valid = v;
        bus_sat.din       = WIDTH'(d);
        bus_sat.clear     = c;
    endtask

    task automatic step(input bit v, input int d, input bit c);
        @(negedge clk);
        drive(v, d, c);
        @(posedge clk);
        model_sample(v, d, c);
        #1;
        check_all();
    endtask

    task automatic good();
        step(1'b1, (m_prev + 1) % MOD, 1'b0);
    endtask

    initial begin
        model_reset();
        drive(1'b0, 0, 1'b0);
        rst = 1'b0;
        #3;
        check("reset_locked",    bus.locked,        0);
        check("reset_err_count", bus.err_count,     0);
        check("reset_last_good", bus.last_good,     0);
        check("reset_pulses",    {bus.err_pulse, bus.restart_pulse}, 0);
        @(negedge clk);
        rst = 1'b1;

        // 1: count 0..15 and wrap to 0,1; lock right after 3.
        for (int i = 0; i < 18; i++) begin
            step(1'b1, i % MOD, 1'b0);
            if (i == 2) check("t1_not_locked_yet", bus.locked, 0);
            if (i == 3) check("t1_locked_after_3", bus.locked, 1);
        end
        check("t1_no_errors", bus.err_count, 0);

        // 2: good up to 5, then 9 is an error; 10,11,12 relock.
        while (m_prev != 5) good();
        check("t2_last_good_5", bus.last_good, 5);
        step(1'b1, 9, 1'b0);
        check("t2_err_pulse", bus.err_pulse, 1);
        check("t2_err_count", bus.err_count, 1);
        check("t2_unlocked",  bus.locked,    0);
        for (int i = 10; i <= 12; i++) step(1'b1, i, 1'b0);
        check("t2_relocked",      bus.locked,    1);
        check("t2_err_pulse_one", bus.err_pulse, 0);

        // 3: locked at 7, jump to 0 is a restart; 1,2,3 relock.
        while (m_prev != 7) good();
        step(1'b1, 0, 1'b0);
        check("t3_restart_pulse", bus.restart_pulse, 1);
        check("t3_no_err_pulse",  bus.err_pulse,     0);
        check("t3_err_count",     bus.err_count,     1);
        for (int i = 1; i <= 3; i++) step(1'b1, i, 1'b0);
        check("t3_relocked", bus.locked, 1);

        // 5: gap with garbage between 4 and 5 keeps lock.
        step(1'b1, 4, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, $urandom_range(0, MOD - 1), 1'b0);
        step(1'b1, 5, 1'b0);
        check("t5_lock_held", bus.locked,    1);
        check("t5_no_error",  bus.err_count, 1);

        // 4: five lock/error cycles saturate the narrow counter.
        for (int k = 0; k < 5; k++) begin
            int bad = (m_prev + 7) % MOD;
            if (bad == 0) bad = (m_prev + 8) % MOD;
            step(1'b1, bad, 1'b0);
            for (int i = 0; i < LOCK_CNT - 1; i++) good();
        end
        check("t4_sat_count",  bus_sat.err_count, 3);
        check("t4_wide_count", bus.err_count,     6);

        // 6: clear alongside a bad sample wins.
        step(1'b1, (m_prev + 5) % MOD, 1'b1);
        check("t6_no_err_pulse", bus.err_pulse, 0);
        check("t6_err_count",    bus.err_count, 0);
        check("t6_unlocked",     bus.locked,    0);
        for (int i = 0; i < 6; i++) step(1'b1, i, 1'b0);

        // 6b: async reset mid-stream clears outputs without a clock edge.
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("arst_locked",    bus.locked,    0);
        check("arst_err_count", bus_sat.err_count, 0);
        check("arst_last_good", bus.last_good, 0);
        model_reset();
        @(negedge clk);
        #1 rst = 1'b1;

        // Random phase.
        for (int n = 0; n < 600; n++) begin
            bit v = ($urandom_range(0, 9) != 0);
            bit c = ($urandom_range(0, 80) == 0);
            int r = $urandom_range(0, 19);
            int d;
            if (r < 15)      d = (m_prev + 1) % MOD;
            else if (r < 17) d = 0;
            else             d = $urandom_range(0, MOD - 1);
            step(v, d, c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
